module_banco_datos_spi_ventana: RTL
===================================

# module_banco_datos_spi_ventana

Parametrised dual-port register bank between the client logic and the SPI engine, replacing the fixed four-entry bank. The client side keeps random addressed access. The SPI side uses an internal auto-incrementing pointer that sweeps a programmable address window, wraps at its end and reports completion. Same-address write collisions are resolved and flagged, and per-entry dirty bits tell the client which words the SPI has refreshed.

## Interface
Parameters:
- N, default 3: address width; bank depth is 2**N entries.
- DATA_WIDTH, default 32: width of each entry.

Ports:
- clk_i  in  1: single clock (10 MHz).
- rst_i  in  1: reset, asynchronous, active-low.
- wr1_i  in  1: client write enable.
- hold_ctrl_i  in  1: when high, blocks client writes.
- addr_1_i  in  N: client address.
- data_in1_i  in  DATA_WIDTH: client write data.
- data1_o  out  DATA_WIDTH: bank[addr_1_i], combinational.
- dirty_clr_i  in  1: clears the dirty bit at addr_1_i.
- ptr_load_i  in  1: loads the window and sets the pointer to ptr_start_i.
- ptr_start_i  in  N: first address of the window.
- ptr_last_i  in  N: last address of the window.
- wr2_i  in  1: SPI writes data_in2_i at the pointer, then advances.
- rd2_i  in  1: SPI consumed data2_o; advance without writing.
- data_in2_i  in  DATA_WIDTH: SPI write data.
- data2_o  out  DATA_WIDTH: bank[ptr2_o], combinational.
- ptr2_o  out  N: current SPI pointer.
- window_done_o  out  1: one-cycle pulse after the advance from the last address.
- collision_o  out  1: one-cycle pulse after a dropped SPI write.
- dirty_o  out  2**N: per-entry "SPI wrote since last client clear" flags.

## Operation
- Reset (rst_i low, asynchronous):
  - All entries are 0, the pointer and start register are 0, and the last register is 2**N-1.
  - window_done_o, collision_o and dirty_o are 0.
  - As a result, data1_o and data2_o read 0.
- Client write: committed when wr1_i=1 and hold_ctrl_i=0. When hold_ctrl_i=1 the bank ignores the write.
- SPI access: effective only when ptr_load_i=0.
  - wr2_i=1 writes bank[ptr] and advances the pointer.
  - rd2_i=1 alone advances the pointer only.
  - wr2_i and rd2_i together act as wr2_i, giving a single advance.
- Pointer advance: if ptr==last, ptr<=start and window_done_o pulses next cycle; otherwise ptr<=ptr+1 mod 2**N.
- Windows with start>last wrap through 2**N-1 to 0. When start==last, every advance completes the window.
- ptr_load_i: captures start and last, and sets ptr<=ptr_start_i. It takes priority over wr2_i/rd2_i in the same cycle: no SPI write, no advance, no done pulse.
- Simultaneous client and SPI writes:
  - Different addresses: both are committed in the same cycle.
  - Same address: the client data is stored and the SPI data is dropped. The pointer still advances and collision_o pulses next cycle.
  - If hold_ctrl_i=1, the SPI write always commits.
- Dirty bits:
  - A committed SPI write sets bit[ptr].
  - A committed client write, or dirty_clr_i, clears bit[addr_1_i].
  - When a set and a clear hit the same entry in one cycle, the set wins. A dropped SPI write does not set its bit.

## Timing
- Writes take effect at the clock edge; a read of the written address shows the new data the following cycle.
- Reads are combinational with zero latency.
- The pointer update is visible on ptr2_o and data2_o the cycle after the wr2_i/rd2_i/ptr_load_i edge.
- window_done_o and collision_o are registered, asserted for exactly one cycle, the cycle after the causing edge.
- Reset asserted mid-window: the pointer, window and flags return to reset values immediately. Any pending done/collision pulse is lost.

## Configuration
- SPI_BANCO_DIRTY_EN defined: dirty_o and the dirty_clr_i logic are implemented as described above.
- SPI_BANCO_DIRTY_EN undefined: no dirty flops are built, dirty_o is tied to 0 and dirty_clr_i is ignored. All other behaviour is unchanged.

## Test plan
- Reset, then read every address via addr_1_i and check ptr2_o: all reads 0, ptr2_o=0, dirty_o=0, no pulses.
- Wrapped window:
  - Stimulus: load start=6, last=1 (N=3), then 4 wr2_i writes of 0xA0..0xA3.
  - Required response: entries 6,7,0,1 hold 0xA0..0xA3 and ptr2_o returns to 6.
  - window_done_o pulses once, the cycle after the fourth write.
- Collision:
  - Stimulus: ptr=2; in one cycle wr1_i at addr 2 with 0x1111 and wr2_i with 0x2222.
  - Required response: bank[2]=0x1111, ptr2_o=3 and collision_o=1 for one cycle; dirty bit 2 not set.
- Hold:
  - Stimulus: hold_ctrl_i=1, wr1_i at addr 4 with 0x55 and wr2_i at ptr 4 with 0x77.
  - Required response: bank[4]=0x77, no collision pulse, dirty bit 4 = 1.
- Load priority:
  - Stimulus: ptr_load_i with start=5 and wr2_i in the same cycle.
  - Required response: no write, ptr2_o=5, no window_done_o.
- Mid-window reset: assert rst_i low asynchronously after 2 writes of a 4-entry window; ptr2_o and all entries read 0 immediately and window_done_o never pulses.

Source files
------------

// File: rtl/module_banco_datos_spi_ventana.sv
// module_banco_datos_spi_ventana: dual-port register bank with a windowed auto-incrementing SPI pointer.
// Optional per-entry dirty flags are built when SPI_BANCO_DIRTY_EN is defined.
module module_banco_datos_spi_ventana #(
    parameter int N          = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr1_i,
    input  logic                  hold_ctrl_i,
    input  logic [N-1:0]          addr_1_i,
    input  logic [DATA_WIDTH-1:0] data_in1_i,
    output logic [DATA_WIDTH-1:0] data1_o,
    input  logic                  dirty_clr_i,
    input  logic                  ptr_load_i,
    input  logic [N-1:0]          ptr_start_i,
    input  logic [N-1:0]          ptr_last_i,
    input  logic                  wr2_i,
    input  logic                  rd2_i,
    input  logic [DATA_WIDTH-1:0] data_in2_i,
    output logic [DATA_WIDTH-1:0] data2_o,
    output logic [N-1:0]          ptr2_o,
    output logic                  window_done_o,
    output logic                  collision_o,
    output logic [2**N-1:0]       dirty_o
);
    localparam int DEPTH = 2**N;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [N-1:0]          ptr_q, ptr_d, start_q, start_d, last_q, last_d;
    logic                  done_q, done_d, coll_q, coll_d;
    logic                  cli_we, spi_adv, spi_req, spi_we;

    always_comb begin
        cli_we  = wr1_i & ~hold_ctrl_i;
        spi_adv = ~ptr_load_i & (wr2_i | rd2_i);
        spi_req = ~ptr_load_i & wr2_i;
        // A held client write never competes, so the SPI write then always lands
        coll_d  = spi_req & cli_we & (addr_1_i == ptr_q);
        spi_we  = spi_req & ~coll_d;
        done_d  = spi_adv & (ptr_q == last_q);
        start_d = ptr_load_i ? ptr_start_i : start_q;
        last_d  = ptr_load_i ? ptr_last_i : last_q;
        ptr_d   = ptr_load_i ? ptr_start_i : !spi_adv ? ptr_q : done_d ? start_q : ptr_q + N'(1);
        mem_d   = mem_q;
        if (spi_we) mem_d[ptr_q] = data_in2_i;
        if (cli_we) mem_d[addr_1_i] = data_in1_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_q   <= '{default: '0};
            ptr_q   <= '0;
            start_q <= '0;
            last_q  <= '1;
            done_q  <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            ptr_q   <= ptr_d;
            start_q <= start_d;
            last_q  <= last_d;
            done_q  <= done_d;
            coll_q  <= coll_d;
        end
    end

    assign data1_o       = mem_q[addr_1_i];
    assign data2_o       = mem_q[ptr_q];
    assign ptr2_o        = ptr_q;
    assign window_done_o = done_q;
    assign collision_o   = coll_q;

`ifdef SPI_BANCO_DIRTY_EN
    logic [DEPTH-1:0] dirty_q, dirty_d;

    // Set is applied last so an SPI refresh beats a same-cycle client clear
    always_comb begin
        dirty_d = dirty_q;
        if (cli_we | dirty_clr_i) dirty_d[addr_1_i] = 1'b0;
        if (spi_we) dirty_d[ptr_q] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) dirty_q <= '0;
        else        dirty_q <= dirty_d;
    end

    assign dirty_o = dirty_q;
`else
    logic unused_dirty_clr;
    assign unused_dirty_clr = dirty_clr_i;
    assign dirty_o          = '0;
`endif

endmodule
